// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares the debug-module register port between the JTAG DTM
// (toggle handshake, synchronised here) and a local host bridge (level
// request). Round-robin arbitration, one DM access at a time, each access
// bounded by a timeout that returns ERR_DATA with an error flag.
module dmi_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  // DTM side (dmi_start toggles in the TCK domain)
  input  logic        dmi_start,
  input  logic [1:0]  dmi_op,
  input  logic [6:0]  dmi_address,
  input  logic [31:0] dmi_data_o,
  output logic        dmi_finish,
  output logic [31:0] dmi_data_i,
  output logic        dmi_err,
  // host bridge side
  input  logic        h_req,
  input  logic [1:0]  h_op,
  input  logic [6:0]  h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  output logic        h_err,
  // debug module port
  output logic        dm_req,
  output logic        dm_we,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // DTM handshake synchroniser and pending flag
  logic r_sync1, r_sync2, r_hist;
  logic r_dtm_pend;

  // control state
  state_t        r_state;
  logic          r_last_dtm;   // 1 = last grant went to the DTM, 0 = host
  logic          r_owner_dtm;  // owner of the access in flight
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_data;
  logic          r_err;

  // registered outputs
  logic        r_dm_req, r_dm_we;
  logic [6:0]  r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic        r_dmi_finish, r_dmi_err;
  logic [31:0] r_dmi_data_i;
  logic        r_h_gnt, r_h_rvalid, r_h_err;
  logic [31:0] r_h_rdata;

  // next-state values
  state_t        w_state_next;
  logic          w_dtm_pend_next, w_last_dtm_next, w_owner_dtm_next;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   w_data_next;
  logic          w_err_next;
  logic          w_dm_req_next, w_dm_we_next;
  logic [6:0]    w_dm_addr_next;
  logic [31:0]   w_dm_wdata_next;
  logic          w_dmi_finish_next, w_dmi_err_next;
  logic [31:0]   w_dmi_data_i_next;
  logic          w_h_gnt_next, w_h_rvalid_next, w_h_err_next;
  logic [31:0]   w_h_rdata_next;

  // arbitration helpers
  logic        w_dtm_edge;
  logic        w_any_req;
  logic        w_pick_dtm;
  logic [1:0]  w_sel_op;
  logic [6:0]  w_sel_addr;
  logic [31:0] w_sel_wdata;

  // A new toggle is seen when the synchronised level differs from history.
  assign w_dtm_edge = r_sync2 ^ r_hist;
  assign w_any_req  = r_dtm_pend | h_req;
  // On a tie the requester that did not win last time goes first.
  assign w_pick_dtm = r_dtm_pend & (~h_req | ~r_last_dtm);
  assign w_sel_op    = w_pick_dtm ? dmi_op      : h_op;
  assign w_sel_addr  = w_pick_dtm ? dmi_address : h_addr;
  assign w_sel_wdata = w_pick_dtm ? dmi_data_o  : h_wdata;

  // Bring the DTM start toggle into the clk domain (two flops + history).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= dmi_start;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Next-state, arbitration and output-register decode.
  always_comb begin
    w_state_next      = r_state;
    w_dtm_pend_next   = r_dtm_pend | w_dtm_edge;
    w_last_dtm_next   = r_last_dtm;
    w_owner_dtm_next  = r_owner_dtm;
    w_cnt_next        = r_cnt;
    w_data_next       = r_data;
    w_err_next        = r_err;
    w_dm_req_next     = r_dm_req;
    w_dm_we_next      = r_dm_we;
    w_dm_addr_next    = r_dm_addr;
    w_dm_wdata_next   = r_dm_wdata;
    w_dmi_finish_next = r_dmi_finish;
    w_dmi_err_next    = r_dmi_err;
    w_dmi_data_i_next = r_dmi_data_i;
    w_h_gnt_next      = 1'b0;
    w_h_rvalid_next   = 1'b0;
    w_h_err_next      = r_h_err;
    w_h_rdata_next    = r_h_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_last_dtm_next  = w_pick_dtm;
          w_owner_dtm_next = w_pick_dtm;
          w_cnt_next       = '0;
          w_dm_we_next     = (w_sel_op == OP_WRITE);
          w_dm_addr_next   = w_sel_addr;
          w_dm_wdata_next  = w_sel_wdata;
          if (w_pick_dtm) begin
            // an edge landing on the grant cycle is kept for a later service
            w_dtm_pend_next = w_dtm_edge;
          end else begin
            w_h_gnt_next = 1'b1;
          end
          if ((w_sel_op == OP_READ) || (w_sel_op == OP_WRITE)) begin
            w_dm_req_next = 1'b1;
            w_state_next  = ST_BUSY;
          end else begin
            // nop: complete without touching the DM
            w_data_next  = '0;
            w_err_next   = 1'b0;
            w_state_next = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        if (dm_ack) begin
          w_dm_req_next = 1'b0;
          w_data_next   = dm_rdata;
          w_err_next    = 1'b0;
          w_state_next  = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_dm_req_next = 1'b0;
          w_data_next   = ERR_DATA;
          w_err_next    = 1'b1;
          w_state_next  = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_RESP: begin
        if (r_owner_dtm) begin
          w_dmi_data_i_next = r_data;
          w_dmi_err_next    = r_err;
          w_dmi_finish_next = ~r_dmi_finish;
        end else begin
          w_h_rvalid_next = 1'b1;
          w_h_rdata_next  = r_data;
          w_h_err_next    = r_err;
        end
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_dm_req_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dtm_pend   <= 1'b0;
      r_last_dtm   <= 1'b0;
      r_owner_dtm  <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_dmi_finish <= 1'b0;
      r_dmi_err    <= 1'b0;
      r_dmi_data_i <= '0;
      r_h_gnt      <= 1'b0;
      r_h_rvalid   <= 1'b0;
      r_h_err      <= 1'b0;
      r_h_rdata    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_dtm_pend   <= w_dtm_pend_next;
      r_last_dtm   <= w_last_dtm_next;
      r_owner_dtm  <= w_owner_dtm_next;
      r_cnt        <= w_cnt_next;
      r_data       <= w_data_next;
      r_err        <= w_err_next;
      r_dm_req     <= w_dm_req_next;
      r_dm_we      <= w_dm_we_next;
      r_dm_addr    <= w_dm_addr_next;
      r_dm_wdata   <= w_dm_wdata_next;
      r_dmi_finish <= w_dmi_finish_next;
      r_dmi_err    <= w_dmi_err_next;
      r_dmi_data_i <= w_dmi_data_i_next;
      r_h_gnt      <= w_h_gnt_next;
      r_h_rvalid   <= w_h_rvalid_next;
      r_h_err      <= w_h_err_next;
      r_h_rdata    <= w_h_rdata_next;
    end
  end

  assign dm_req     = r_dm_req;
  assign dm_we      = r_dm_we;
  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;
  assign dmi_finish = r_dmi_finish;
  assign dmi_data_i = r_dmi_data_i;
  assign dmi_err    = r_dmi_err;
  assign h_gnt      = r_h_gnt;
  assign h_rvalid   = r_h_rvalid;
  assign h_rdata    = r_h_rdata;
  assign h_err      = r_h_err;

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed vectors for dmi_arbiter with a small DM responder
// and an event monitor; expected values are hand-computed constants.
module tb_dmi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_start;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic        dmi_finish;
  logic [31:0] dmi_data_i;
  logic        dmi_err;
  logic        h_req;
  logic [1:0]  h_op;
  logic [6:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_gnt, h_rvalid, h_err;
  logic [31:0] h_rdata;
  logic        dm_req, dm_we;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;

  dmi_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_start(dmi_start), .dmi_op(dmi_op), .dmi_address(dmi_address),
    .dmi_data_o(dmi_data_o), .dmi_finish(dmi_finish), .dmi_data_i(dmi_data_i),
    .dmi_err(dmi_err),
    .h_req(h_req), .h_op(h_op), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // DM responder / monitor state
  int          ack_delay = -1;   // cycles of dm_req before ack; -1 = never
  logic [31:0] rdata_val = 32'h0;
  int          req_cycles = 0, last_len = 0, req_starts = 0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
  int          fin_cnt = 0, gnt_cnt = 0, rv_cnt = 0;
  logic        prev_fin = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_herr = 1'b0;
  int          order[$];          // completion order: 0 = DTM, 1 = host

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor and DM model, evaluated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_fin   = 1'b0;
      req_cycles = 0;
      dm_ack     = 1'b0;
    end else begin
      if (dmi_finish != prev_fin) begin
        fin_cnt++;
        order.push_back(0);
      end
      prev_fin = dmi_finish;
      if (h_gnt) gnt_cnt++;
      if (h_rvalid) begin
        rv_cnt++;
        order.push_back(1);
        last_rdata = h_rdata;
        last_herr  = h_err;
      end
      if (dm_req) begin
        if (req_cycles == 0) begin
          req_starts++;
          cap_we    = dm_we;
          cap_addr  = {25'd0, dm_addr};
          cap_wdata = dm_wdata;
        end
        req_cycles++;
        dm_ack   = (req_cycles == ack_delay);
        dm_rdata = rdata_val;
      end else begin
        if (req_cycles != 0) last_len = req_cycles;
        req_cycles = 0;
        dm_ack     = 1'b0;
      end
    end
  end

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, dm_req, dm_we, dmi_finish, dmi_err, h_gnt, h_rvalid, h_err, 1'b0}, 32'h0);
    chk({tag, "_addr"}, {25'd0, dm_addr}, 32'h0);
    chk({tag, "_wdata"}, dm_wdata, 32'h0);
    chk({tag, "_dmi_data"}, dmi_data_i, 32'h0);
    chk({tag, "_h_rdata"}, h_rdata, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = 7'd0; dmi_data_o = 32'd0;
    h_req = 1'b0; h_op = 2'd0; h_addr = 7'd0; h_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rv(input int target, input string tag);
    int n = 0;
    while (rv_cnt < target && n < 300) begin @(negedge clk); n++; end
    chk(tag, rv_cnt, target);
  endtask

  task automatic wait_fin(input int target, input string tag);
    int n = 0;
    while (fin_cnt < target && n < 300) begin @(negedge clk); n++; end
    chk(tag, fin_cnt, target);
  endtask

  // Raise a host request and hold it until the grant is seen.
  task automatic host_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d, input string tag);
    int n = 0;
    h_op = op; h_addr = a; h_wdata = d; h_req = 1'b1;
    while (!h_gnt && n < 100) begin @(negedge clk); n++; end
    h_req = 1'b0;
    chk(tag, h_gnt, 1);
  endtask

  task automatic dtm_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    dmi_op = op; dmi_address = a; dmi_data_o = d;
    dmi_start = ~dmi_start;
  endtask

  // DTM toggle and host request timed to be pending on the same IDLE edge.
  task automatic tie_round(input string tag);
    int f0, r0;
    f0 = fin_cnt; r0 = rv_cnt;
    order.delete();
    dtm_req(2'd1, 7'h20, 32'd0);
    repeat (3) @(negedge clk);
    host_req(2'd1, 7'h21, 32'd0, {tag, "_gnt"});
    wait_fin(f0 + 1, {tag, "_fin"});
    wait_rv(r0 + 1, {tag, "_rv"});
    chk({tag, "_nevents"}, order.size(), 2);
  endtask

  initial begin
    int g0, r0, f0, s0, first;

    // reset values
    do_reset();
    @(negedge clk);
    outs_zero("reset");

    // tie right after reset: DTM first (last_gnt resets to host)
    ack_delay = 1; rdata_val = 32'hA5A5_0000;
    tie_round("tie1");
    first = (order.size() > 0) ? order[0] : 99;
    chk("tie1_first_dtm", first, 0);

    // lone DTM request moves last_gnt to DTM
    f0 = fin_cnt;
    dtm_req(2'd1, 7'h22, 32'd0);
    wait_fin(f0 + 1, "lone_dtm_fin");

    // next tie: host first
    tie_round("tie2");
    first = (order.size() > 0) ? order[0] : 99;
    chk("tie2_first_host", first, 1);

    // host read, ack after 2 cycles
    repeat (2) @(negedge clk);
    ack_delay = 2; rdata_val = 32'hCAFE_0001;
    g0 = gnt_cnt; r0 = rv_cnt;
    host_req(2'd1, 7'h11, 32'd0, "hrd_gnt");
    wait_rv(r0 + 1, "hrd_done");
    repeat (3) @(negedge clk);
    chk("hrd_gnt_pulse", gnt_cnt - g0, 1);
    chk("hrd_rv_pulse", rv_cnt - r0, 1);
    chk("hrd_req_len", last_len, 2);
    chk("hrd_we", cap_we, 0);
    chk("hrd_addr", cap_addr, 32'h11);
    chk("hrd_rdata", last_rdata, 32'hCAFE_0001);
    chk("hrd_err", last_herr, 0);

    // DTM write
    ack_delay = 1;
    f0 = fin_cnt;
    dtm_req(2'd2, 7'h10, 32'h0000_0001);
    wait_fin(f0 + 1, "dwr_fin");
    repeat (5) @(negedge clk);
    chk("dwr_fin_once", fin_cnt - f0, 1);
    chk("dwr_we", cap_we, 1);
    chk("dwr_addr", cap_addr, 32'h10);
    chk("dwr_wdata", cap_wdata, 32'h1);
    chk("dwr_err", dmi_err, 0);
    chk("dwr_hold_addr", {25'd0, dm_addr}, 32'h10);

    // host timeout, then a normal host read
    ack_delay = -1;
    r0 = rv_cnt;
    host_req(2'd1, 7'h05, 32'd0, "hto_gnt");
    wait_rv(r0 + 1, "hto_done");
    chk("hto_req_len", last_len, 8);
    chk("hto_rdata", last_rdata, 32'hFFFF_FFFF);
    chk("hto_err", last_herr, 1);
    ack_delay = 1; rdata_val = 32'h1234_5678;
    host_req(2'd1, 7'h06, 32'd0, "hafter_gnt");
    wait_rv(r0 + 2, "hafter_done");
    chk("hafter_rdata", last_rdata, 32'h1234_5678);
    chk("hafter_err", last_herr, 0);

    // DTM timeout
    ack_delay = -1;
    f0 = fin_cnt;
    dtm_req(2'd1, 7'h30, 32'd0);
    wait_fin(f0 + 1, "dto_fin");
    chk("dto_req_len", last_len, 8);
    chk("dto_data", dmi_data_i, 32'hFFFF_FFFF);
    chk("dto_err", dmi_err, 1);

    // DTM nop: no DM access, data 0
    ack_delay = 1;
    s0 = req_starts; f0 = fin_cnt;
    dtm_req(2'd0, 7'h31, 32'd0);
    wait_fin(f0 + 1, "nop_fin");
    repeat (3) @(negedge clk);
    chk("nop_no_req", req_starts - s0, 0);
    chk("nop_data", dmi_data_i, 32'h0);
    chk("nop_err", dmi_err, 0);
    chk("nop_fin_once", fin_cnt - f0, 1);

    // reset in the middle of an access
    ack_delay = -1;
    host_req(2'd1, 7'h44, 32'd0, "rst_gnt");
    repeat (2) @(negedge clk);
    chk("rst_busy_req", dm_req, 1);
    #2 rst_n = 1'b0;
    #1 outs_zero("rst_async");
    do_reset();
    r0 = rv_cnt; f0 = fin_cnt;
    repeat (20) @(negedge clk);
    chk("rst_no_rv", rv_cnt - r0, 0);
    chk("rst_no_fin", fin_cnt - f0, 0);
    chk("rst_req_low", dm_req, 0);
    ack_delay = 1; rdata_val = 32'h0BAD_F00D;
    host_req(2'd1, 7'h45, 32'd0, "post_gnt");
    wait_rv(r0 + 1, "post_done");
    chk("post_rdata", last_rdata, 32'h0BAD_F00D);
    chk("post_err", last_herr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares the single debug-module (DM) register port between the JTAG DTM and a local host debug bridge. It runs in the system clock domain and synchronises the DTM's toggle start/finish handshake. It round-robin arbitrates between the two requesters, runs one DM access at a time with a timeout, and returns read data and an error indication to the requester that issued the access.

## Interface
- TIMEOUT, 64: maximum number of cycles dm_req stays high waiting for dm_ack; must be ≥2.
- ERR_DATA, 32'hFFFF_FFFF: read data returned when an access times out.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- dmi_start  in  1  toggle from the DTM, in the TCK domain; each change is one request.
- dmi_op  in  2  DTM op: 1 = read, 2 = write, 0/3 = nop. Stable while a request is pending.
- dmi_address  in  7  DTM register address.
- dmi_data_o  in  32  DTM write data.
- dmi_finish  out  1  toggle to the DTM; changes once per completed DTM request.
- dmi_data_i  out  32  read data returned to the DTM.
- dmi_err  out  1  1 if the last completed DTM access timed out.
- h_req  in  1  host request, level; held until h_gnt.
- h_op, h_addr, h_wdata  in  2/7/32  host op, address and write data; same encoding as the DTM.
- h_gnt  out  1  one-cycle pulse when the host request is accepted.
- h_rvalid  out  1  one-cycle completion pulse.
- h_rdata  out  32  completion read data.
- h_err  out  1  completion timeout flag; valid with h_rvalid.
- dm_req  out  1  DM access request; held high until dm_ack or timeout.
- dm_we, dm_addr, dm_wdata  out  1/7/32  DM write enable, address and write data.
- dm_ack  in  1  DM completion; valid only while dm_req = 1.
- dm_rdata  in  32  DM read data; valid with dm_ack.

## Operation
- DTM input path:
  - dmi_start passes through two synchroniser flops plus one history flop.
  - A mismatch between the synchronised value and the history flop sets dtm_pend.
  - dtm_pend clears when the DTM request is granted.
  - An edge arriving while dtm_pend is already 1 is merged into it: one service, one finish toggle.
  - An edge arriving while a DTM access is in service sets dtm_pend again for a later service.
- Host request: h_req = 1 in IDLE is a pending host request.
- Arbitration happens only in IDLE.
  - A single pending requester is granted.
  - If both are pending, the requester other than last_gnt wins. last_gnt resets to host, so the DTM wins the first tie.
  - last_gnt updates on every grant.
- At grant the arbiter latches op, address and write data from the winner, and clears the timeout counter.
- States:
  - IDLE: on grant, go to BUSY if op is 1 or 2. For a nop op, go to RESP with data 0, error 0 and no DM access.
  - BUSY: dm_req = 1, dm_we = (op == 2). On dm_ack, capture dm_rdata (writes capture it too, but it is not meaningful) with error 0, drop dm_req and go to RESP. Otherwise the counter increments; when it equals TIMEOUT-1 with no ack, drop dm_req, load ERR_DATA with error 1 and go to RESP.
  - RESP: for a DTM owner, dmi_data_i ← data, dmi_err ← error, dmi_finish toggles. For a host owner, h_rvalid ← 1, h_rdata ← data, h_err ← error. Then go to IDLE.
- A dm_ack received outside BUSY is ignored.
- dm_addr, dm_wdata and dm_we hold their latched values until the next grant.
- Asynchronous reset at any point:
  - State → IDLE; all outputs, flags and synchroniser flops → 0.
  - An in-flight access is abandoned with no completion signalled.
  - dmi_finish resets to 0, matching the DTM's reset value of dmi_start.

## Timing
- Reset values are 0 for all outputs: dm_req, dm_we, dm_addr, dm_wdata, dmi_finish, dmi_data_i, dmi_err, h_gnt, h_rvalid, h_rdata, h_err.
- DTM synchronisation: dtm_pend is 1 after the 3rd rising clk edge that samples the new dmi_start value.
- Grant at edge k (IDLE sees a pending request):
  - dm_req = 1 from k.
  - h_gnt = 1 in cycle k only.
- Ack:
  - If dm_ack = 1 is sampled at edge k+n (n ≥ 1), dm_req = 0 from k+n and the state is RESP.
  - At edge k+n+1, completion is signalled: h_rvalid high for one cycle, or dmi_finish toggles. The state returns to IDLE.
  - The next grant can occur at edge k+n+2.
  - Minimum service time is 3 cycles from grant to the next grant.
- Timeout: dm_req is high for exactly TIMEOUT cycles, then completion follows one cycle later.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Host read at address 0x11 with the DM acking after 2 cycles carrying 0xCAFE0001 -> h_gnt is a 1-cycle pulse at grant, dm_req is high for 2 cycles with dm_we = 0, h_rvalid pulses once with h_rdata = 0xCAFE0001 and h_err = 0.
- DTM write (dmi_start toggled, op = 2, address 0x10, data 0x00000001) -> dm_we = 1, dm_addr = 0x10, dm_wdata = 1; dmi_finish toggles exactly once; dmi_err = 0.
- Both requesters pending at reset exit -> DTM is served first, host second; repeating simultaneous requests alternate DTM/host.
- DM never acks with TIMEOUT = 8 -> dm_req is high for exactly 8 cycles; completion carries 0xFFFFFFFF with error 1; the arbiter then accepts the next request.
- DTM op = 0 -> no dm_req; dmi_finish toggles; dmi_data_i = 0.
- rst_n asserted mid-BUSY -> all outputs are 0 immediately; there is no completion pulse after release; a new host request is then served normally.
